// File: rtl/ps2_line_pkg.sv
// Shared types and constants for the PS/2 line assembler: decoder states,
// set-2 scan codes that steer the FSM, and the empty-slot character.
package ps2_line_pkg;

    typedef enum logic [2:0] {
        S_MAKE,
        S_BREAK,
        S_EXT,
        S_EXT_BREAK,
        S_COMMIT
    } state_t;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_BKSP   = 8'h66;

    localparam logic [7:0] NUL = 8'h00;

endpackage

// File: rtl/ps2_scancode_to_ascii.sv
// Combinational scan-code set 2 to ASCII map; printable=0 for keys that
// produce no character.
module ps2_scancode_to_ascii
    import ps2_line_pkg::*;
(
    input  logic [7:0] scan_code,
    input  logic       shift,
    output logic [7:0] ascii,
    output logic       printable
);

    logic [7:0] base;
    logic       is_letter;

    always_comb begin
        base      = NUL;
        printable = 1'b1;
        is_letter = 1'b1;
        case (scan_code)
            8'h1C: base = 8'h61; 8'h32: base = 8'h62; 8'h21: base = 8'h63;
            8'h23: base = 8'h64; 8'h24: base = 8'h65; 8'h2B: base = 8'h66;
            8'h34: base = 8'h67; 8'h33: base = 8'h68; 8'h43: base = 8'h69;
            8'h3B: base = 8'h6A; 8'h42: base = 8'h6B; 8'h4B: base = 8'h6C;
            8'h3A: base = 8'h6D; 8'h31: base = 8'h6E; 8'h44: base = 8'h6F;
            8'h4D: base = 8'h70; 8'h15: base = 8'h71; 8'h2D: base = 8'h72;
            8'h1B: base = 8'h73; 8'h2C: base = 8'h74; 8'h3C: base = 8'h75;
            8'h2A: base = 8'h76; 8'h1D: base = 8'h77; 8'h22: base = 8'h78;
            8'h35: base = 8'h79; 8'h1A: base = 8'h7A;
            default: begin
                is_letter = 1'b0;
                case (scan_code)
                    8'h45: base = 8'h30; 8'h16: base = 8'h31; 8'h1E: base = 8'h32;
                    8'h26: base = 8'h33; 8'h25: base = 8'h34; 8'h2E: base = 8'h35;
                    8'h36: base = 8'h36; 8'h3D: base = 8'h37; 8'h3E: base = 8'h38;
                    8'h46: base = 8'h39;
                    8'h29: base = 8'h20; 8'h4E: base = 8'h2D;
                    8'h49: base = 8'h2E; 8'h41: base = 8'h2C;
                    default: printable = 1'b0;
                endcase
            end
        endcase
        // Upper case is lower case minus 0x20; digits and punctuation ignore shift.
        ascii = (is_letter && shift) ? base - 8'h20 : base;
    end

endmodule

// File: rtl/ps2_line_assembler.sv
// Turns a stream of PS/2 set-2 bytes into an editable text line and hands
// the finished line to the screen writer with a one-cycle ready pulse on Enter.
module ps2_line_assembler
    import ps2_line_pkg::*;
#(
    parameter int MAX_CHARS = 32,
    parameter int CHAR_W    = 8
) (
    input  logic                               clock,
    input  logic                               reset,
    input  logic [7:0]                         ps2_key_data,
    input  logic                               ps2_key_pressed,
    output logic [MAX_CHARS*CHAR_W-1:0]        ps2_line_content,
    output logic                               ps2_line_ready,
    output logic [$clog2(MAX_CHARS+1)-1:0]     ps2_line_length,
    output logic                               ps2_line_full
);

    localparam int LINE_W = MAX_CHARS * CHAR_W;
    localparam int LEN_W  = $clog2(MAX_CHARS + 1);
    localparam int POS_W  = $clog2(LINE_W);

    state_t              state_q, state_d;
    logic [LINE_W-1:0]   content_q, content_d;
    logic [LEN_W-1:0]    length_q, length_d;
    logic                lshift_q, lshift_d;
    logic                rshift_q, rshift_d;

    logic [7:0]          ascii;
    logic                printable;
    logic                full;
    logic [POS_W-1:0]    wr_pos, bs_pos;

    ps2_scancode_to_ascii u_map (
        .scan_code (ps2_key_data),
        .shift     (lshift_q | rshift_q),
        .ascii     (ascii),
        .printable (printable)
    );

    assign full   = (length_q == LEN_W'(MAX_CHARS));
    // Only used when in range: wr_pos when not full, bs_pos when length>0.
    assign wr_pos = POS_W'(32'(length_q) * CHAR_W);
    assign bs_pos = POS_W'((32'(length_q) - 32'd1) * CHAR_W);

    always_comb begin
        state_d   = state_q;
        content_d = content_q;
        length_d  = length_q;
        lshift_d  = lshift_q;
        rshift_d  = rshift_q;
        if (state_q == S_COMMIT) begin
            // Strobes landing here are dropped; bytes are far apart in practice.
            content_d = '0;
            length_d  = '0;
            state_d   = S_MAKE;
        end else if (ps2_key_pressed) begin
            case (state_q)
                S_MAKE: begin
                    if (ps2_key_data == SC_BREAK)       state_d = S_BREAK;
                    else if (ps2_key_data == SC_EXT)    state_d = S_EXT;
                    else if (ps2_key_data == SC_LSHIFT) lshift_d = 1'b1;
                    else if (ps2_key_data == SC_RSHIFT) rshift_d = 1'b1;
                    else if (ps2_key_data == SC_ENTER)  state_d = S_COMMIT;
                    else if (ps2_key_data == SC_BKSP) begin
                        if (length_q != '0) begin
                            content_d[bs_pos +: CHAR_W] = CHAR_W'(NUL);
                            length_d = length_q - LEN_W'(1);
                        end
                    end else if (printable && !full) begin
                        content_d[wr_pos +: CHAR_W] = CHAR_W'(ascii);
                        length_d = length_q + LEN_W'(1);
                    end
                end
                S_BREAK: begin
                    if (ps2_key_data == SC_LSHIFT) lshift_d = 1'b0;
                    if (ps2_key_data == SC_RSHIFT) rshift_d = 1'b0;
                    state_d = S_MAKE;
                end
                S_EXT: begin
                    if (ps2_key_data == SC_BREAK)      state_d = S_EXT_BREAK;
                    else if (ps2_key_data == SC_ENTER) state_d = S_COMMIT;
                    else                               state_d = S_MAKE;
                end
                default: state_d = S_MAKE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= S_MAKE;
            content_q <= '0;
            length_q  <= '0;
            lshift_q  <= 1'b0;
            rshift_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            content_q <= content_d;
            length_q  <= length_d;
            lshift_q  <= lshift_d;
            rshift_q  <= rshift_d;
        end
    end

    assign ps2_line_content = content_q;
    assign ps2_line_length  = length_q;
    assign ps2_line_full    = full;
    assign ps2_line_ready   = (state_q == S_COMMIT);

endmodule

// File: tb/tb_ps2_line_assembler.sv
// Directed bench for ps2_line_assembler: typing, shift, backspace, overflow,
// keypad Enter, commit pulse and mid-line reset.
module tb_ps2_line_assembler;

    logic         clock = 1'b0;
    logic         reset;
    logic [7:0]   ps2_key_data;
    logic         ps2_key_pressed;
    logic [255:0] ps2_line_content;
    logic         ps2_line_ready;
    logic [5:0]   ps2_line_length;
    logic         ps2_line_full;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    ps2_line_assembler dut (
        .clock            (clock),
        .reset            (reset),
        .ps2_key_data     (ps2_key_data),
        .ps2_key_pressed  (ps2_key_pressed),
        .ps2_line_content (ps2_line_content),
        .ps2_line_ready   (ps2_line_ready),
        .ps2_line_length  (ps2_line_length),
        .ps2_line_full    (ps2_line_full)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Returns on the falling edge after the strobe was sampled.
    task automatic send(input logic [7:0] b);
        @(negedge clock);
        ps2_key_data    = b;
        ps2_key_pressed = 1'b1;
        @(negedge clock);
        ps2_key_pressed = 1'b0;
        ps2_key_data    = 8'h00;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".content"}, ps2_line_content, '0);
        chk({tag, ".length"},  256'(ps2_line_length), 256'd0);
        chk({tag, ".ready"},   256'(ps2_line_ready), 256'd0);
        chk({tag, ".full"},    256'(ps2_line_full), 256'd0);
    endtask

    task automatic commit_and_clear();
        send(8'h5A);
        @(negedge clock);
    endtask

    logic [255:0] all_a;

    initial begin
        reset = 1'b1;
        ps2_key_data = 8'h00;
        ps2_key_pressed = 1'b0;
        repeat (2) @(negedge clock);
        chk_all_zero("reset");
        reset = 1'b0;

        // "hello" then Enter
        send(8'h33); send(8'h24); send(8'h4B); send(8'h4B); send(8'h44);
        chk("hello.content", ps2_line_content, 256'h6F6C6C6568);
        chk("hello.length", 256'(ps2_line_length), 256'd5);
        send(8'h5A);
        chk("enter.ready", 256'(ps2_line_ready), 256'd1);
        chk("enter.content_held", ps2_line_content, 256'h6F6C6C6568);
        chk("enter.length_held", 256'(ps2_line_length), 256'd5);
        @(negedge clock);
        chk_all_zero("after_commit");

        // Shift press and release
        send(8'h12); send(8'h1C);
        chk("shift.upper", ps2_line_content, 256'h41);
        send(8'hF0); send(8'h12); send(8'h1C);
        chk("shift.released", ps2_line_content, 256'h6141);
        chk("shift.length", 256'(ps2_line_length), 256'd2);
        commit_and_clear();

        // Right shift: digits/punctuation unaffected, unmapped ignored, release
        send(8'h59); send(8'h16); send(8'h4E); send(8'h29); send(8'h49); send(8'h41);
        send(8'h76); send(8'hF0); send(8'h59); send(8'h15);
        chk("rshift.content", ps2_line_content, 256'h712C2E202D31);
        chk("rshift.length", 256'(ps2_line_length), 256'd6);
        commit_and_clear();

        // Backspace down to zero, extra one is a no-op
        send(8'h16); send(8'h1E);
        chk("bksp.len2", 256'(ps2_line_length), 256'd2);
        chk("bksp.content2", ps2_line_content, 256'h3231);
        send(8'h66);
        chk("bksp.len1", 256'(ps2_line_length), 256'd1);
        chk("bksp.content1", ps2_line_content, 256'h31);
        send(8'h66);
        chk("bksp.len0", 256'(ps2_line_length), 256'd0);
        send(8'h66);
        chk("bksp.noop_len", 256'(ps2_line_length), 256'd0);
        chk("bksp.noop_content", ps2_line_content, '0);

        // Overflow: 33 keys, only 32 stored
        for (int i = 0; i < 32; i++) send(8'h1C);
        all_a = {32{8'h61}};
        chk("fill.length", 256'(ps2_line_length), 256'd32);
        chk("fill.full", 256'(ps2_line_full), 256'd1);
        send(8'h32);
        chk("over.length", 256'(ps2_line_length), 256'd32);
        chk("over.content", ps2_line_content, all_a);
        send(8'h66);
        chk("unfill.length", 256'(ps2_line_length), 256'd31);
        chk("unfill.full", 256'(ps2_line_full), 256'd0);
        chk("unfill.content", ps2_line_content, {8'h00, all_a[247:0]});
        commit_and_clear();

        // Keypad Enter
        send(8'h16); send(8'h1E); send(8'hE0); send(8'h5A);
        chk("kpenter.ready", 256'(ps2_line_ready), 256'd1);
        chk("kpenter.content", ps2_line_content, 256'h3231);
        @(negedge clock);
        chk_all_zero("kpenter.cleared");
        send(8'hE0); send(8'hF0); send(8'h5A);
        chk("kprelease.ready", 256'(ps2_line_ready), 256'd0);
        @(negedge clock);
        chk("kprelease.ready2", 256'(ps2_line_ready), 256'd0);
        send(8'hF0); send(8'h16);
        chk("brk16.length", 256'(ps2_line_length), 256'd0);
        send(8'h16);
        chk("make16.content", ps2_line_content, 256'h31);

        // Reset mid-line and mid-prefix
        send(8'h1E); send(8'h26); send(8'h25);
        chk("pre_rst.length", 256'(ps2_line_length), 256'd4);
        do_reset();
        chk_all_zero("rst_midline");
        send(8'hF0);
        do_reset();
        chk_all_zero("rst_prefix");
        send(8'h16);
        chk("post_rst.content", ps2_line_content, 256'h31);
        chk("post_rst.length", 256'(ps2_line_length), 256'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/ps2_line_assembler.md
Name: ps2_line_assembler

Overview:
- Producer side of the ps2_line_content / ps2_line_ready interface consumed by the display controller's screen-character writer.
- Accepts raw PS/2 scan-code set 2 bytes, one strobe per byte, from the PS/2 byte receiver.
- Tracks make/break/extended prefixes and shift state, translates keys to ASCII, and edits a fixed-width line buffer.
- On Enter, presents the completed line with a one-cycle ready pulse, then clears the buffer.

Parameters:
- MAX_CHARS, 32, line capacity in characters.
- CHAR_W, 8, bits per character (ASCII); line width = MAX_CHARS*CHAR_W = 256.

Ports:
- clock  in  1  system clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- ps2_key_data  in  8  received scan-code byte, valid when ps2_key_pressed=1.
- ps2_key_pressed  in  1  one-cycle strobe per received byte.
- ps2_line_content  out  256  live line buffer; char i at bits [8i+7:8i], char 0 typed first, unused slots 8'h00.
- ps2_line_ready  out  1  one-cycle pulse, line committed.
- ps2_line_length  out  6  current character count, 0..32.
- ps2_line_full  out  1  high when ps2_line_length==MAX_CHARS.

Behaviour:
- Reset (sync, active-high): content all 0, length 0, ready 0, full 0, shift flags clear, FSM in S_MAKE.
- Decoder FSM; it only advances on a strobe cycle.
  - S_MAKE: F0 -> S_BREAK; E0 -> S_EXT; any other byte is a make code, acted on, stay in S_MAKE.
  - S_BREAK: next byte is a release. 12 clears lshift, 59 clears rshift, others ignored. -> S_MAKE.
  - S_EXT: F0 -> S_EXT_BREAK; 5A (keypad Enter) treated as Enter; any other byte ignored. -> S_MAKE.
  - S_EXT_BREAK: byte ignored -> S_MAKE.
  - S_COMMIT: entered after Enter, lasts exactly 1 cycle, then -> S_MAKE.
- Make-code actions:
  - 12 sets lshift; 59 sets rshift. shift = lshift|rshift.
  - 66 (Backspace): if length>0, char[length-1]=00 and length-1; at length 0, no-op.
  - 5A (Enter): -> S_COMMIT.
  - Printable key: if length<MAX_CHARS, char[length]=ascii and length+1; if full, the key is ignored and nothing changes.
  - Unmapped codes: ignored.
- ASCII map:
  - Letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A map to a..z, or A..Z when shift=1.
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 map to 0..9 regardless of shift.
  - 29 maps to space (20), 4E to '-' (2D), 49 to '.' (2E), 41 to ',' (2C).
- Commit timing: Enter strobe sampled at cycle N.
  - Cycle N+1: ready=1 and content holds the completed line unchanged.
  - Cycle N+2: ready=0, content all 0, length 0, full 0.
  - Enter with length 0 still pulses ready, with all-zero content.
- A strobe arriving during S_COMMIT is dropped. PS/2 bytes are ≥1000 clocks apart, so this is acceptable.
- Shift flags survive commit; only reset or a break code clears them.
- Latency: a make code shows up in content/length on the cycle after its strobe.
- full is combinational from length.
- Reset mid-line or mid-prefix returns everything to its reset values on the next edge.

Decomposition:
- Package ps2_line_pkg holds:
  - FSM state enum (S_MAKE, S_BREAK, S_EXT, S_EXT_BREAK, S_COMMIT).
  - Scan-code constants: SC_BREAK=F0, SC_EXT=E0, SC_LSHIFT=12, SC_RSHIFT=59, SC_ENTER=5A, SC_BKSP=66.
  - NUL character constant.
- One sub-module, ps2_scancode_to_ascii: combinational map from (scan code, shift) to (ascii[7:0], printable flag).

Test Plan:
- Strobe 33,24,4B,4B,44 -> content[39:0]=6F_6C_6C_65_68 ("hello"), length 5; Enter -> ready=1 for exactly one cycle with content unchanged, next cycle content 0 and length 0.
- 12, 1C, F0 12, 1C -> "Aa" (41 then 61); release of shift confirmed by the second 1C giving lowercase.
- Type 16,1E then 66,66,66 -> length 2,1,0,0 (third backspace no-op); content all 0.
- Type 33 printable keys -> length saturates at 32, full=1, 33rd byte absent; 66 -> length 31, full=0.
- E0 5A on a line "12" -> ready pulse with content[15:0]=32_31; E0 F0 5A afterwards -> no second pulse; F0 16 -> no character added.
- Reset asserted mid-line after 4 chars and after a lone F0 -> all outputs 0 next cycle; the next 16 types '1', proving the FSM is back in S_MAKE.
